// File: rtl/lcd_video_pkg.sv
// Shared types and helpers for the Supervision LCD video path:
// frame-store geometry, intensity type, palette select and colour mapping.
package lcd_video_pkg;

  localparam int MAX_W       = 160;
  localparam int MAX_H       = 160;
  localparam int STORE_DEPTH = MAX_W * MAX_H;
  localparam int ADDR_W      = 15;

  typedef logic [3:0] intensity_t;

  typedef enum logic {
    GREY  = 1'b0,
    GREEN = 1'b1
  } pal_sel_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // LCD level 0 (lightest) .. 3 (darkest) becomes intensity 15 - 5*level.
  function automatic intensity_t level_to_intensity(input logic [1:0] level);
    logic [5:0] five_x;
    logic [5:0] diff;
    five_x = {2'b00, level, 2'b00} + {4'b0000, level};
    diff   = 6'd15 - five_x;
    return diff[3:0];
  endfunction

  // Grey spreads I evenly over 0..255 (I*17). Green uses I*8 / I*16+15 / I*4;
  // the green channel tops out at exactly 255 for I=15, so it never needs clipping.
  function automatic rgb_t palette(input intensity_t i, input pal_sel_e sel);
    rgb_t c;
    if (sel == GREEN) begin
      c.r = {1'b0, i, 3'b000};
      c.g = {i, 4'hF};
      c.b = {2'b00, i, 2'b00};
    end else begin
      c.r = {i, i};
      c.g = {i, i};
      c.b = {i, i};
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_ghost_ram.sv
// Simple dual-port frame store: one registered read port, one write port,
// both on clk. Written so synthesis maps it onto block RAM.
module lcd_ghost_ram #(
  parameter int DEPTH  = 25600,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; read-during-write on the same address is don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, held between enables so data lines up with the pixel pipeline.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_ghost_blend.sv
// LCD ghosting emulation: averages each pixel with its value from the previous
// frame (held in a 160x160 store) and maps the result through a grey or green palette.
// Two ce_pix stages of latency; sync/blank signals are delayed to match.
module lcd_ghost_blend #(
  parameter int MAX_W = 160,
  parameter int MAX_H = 160,
  parameter int I_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] pixel,
  input  logic       hblank_in,
  input  logic       vblank_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       ghost_en,
  input  logic       palette_sel,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync
);

  import lcd_video_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DEPTH = MAX_W * MAX_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0]  addr_cnt;
  logic [AW-1:0]  s0_addr;
  intensity_t     s0_new;
  logic           s0_active;
  logic           s0_ghost;
  pal_sel_e       s0_pal;
  logic [3:0]     s0_sync;
  logic           first_frame;
  logic [I_W-1:0] old_int;
  logic           active_in;
  logic [4:0]     sum;
  intensity_t     blend_int;
  intensity_t     sel_int;
  rgb_t           color;
  logic           wr_en;

  lcd_ghost_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (I_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ce_pix),
    .rd_addr (addr_cnt),
    .rd_data (old_int),
    .wr_en   (wr_en),
    .wr_addr (s0_addr),
    .wr_data (sel_int)
  );

  // Stage 1: blend with last frame's value (skipped until a full frame has been stored), colour and write back.
  always_comb begin
    active_in = !hblank_in && !vblank_in;
    sum       = {1'b0, s0_new} + {1'b0, old_int};
    blend_int = sum[4:1];
    sel_int   = (s0_ghost && !first_frame) ? blend_int : s0_new;
    color     = s0_active ? palette(sel_int, s0_pal) : '0;
    wr_en     = ce_pix && s0_active && !reset;
  end

  // Pixel pipeline, address counter and first-frame tracking; reset overrides the ce update.
  always_ff @(posedge clk) begin
    if (ce_pix) begin
      s0_new    <= level_to_intensity(pixel);
      s0_addr   <= addr_cnt;
      s0_active <= active_in;
      s0_ghost  <= ghost_en;
      s0_pal    <= pal_sel_e'(palette_sel);
      s0_sync   <= {hblank_in, vblank_in, hsync_in, vsync_in};
      if (vblank_in)
        addr_cnt <= '0;
      else if (active_in && addr_cnt != LAST_ADDR)
        addr_cnt <= addr_cnt + 1'b1;
      if (vblank_in && !s0_sync[2])
        first_frame <= 1'b0;
      r <= color.r;
      g <= color.g;
      b <= color.b;
      {hblank, vblank, hsync, vsync} <= s0_sync;
    end
    if (reset) begin
      s0_new      <= '0;
      s0_addr     <= '0;
      s0_active   <= 1'b0;
      s0_ghost    <= 1'b0;
      s0_pal      <= GREY;
      s0_sync     <= '0;
      addr_cnt    <= '0;
      first_frame <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_ghost_blend.sv
// Scoreboard bench for lcd_ghost_blend: stimulus pushes the expected output
// (due two ce pulses later) into a queue, a monitor pops and compares on every ce edge.
module tb_lcd_ghost_blend;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic [1:0] pixel;
  logic       hblank_in, vblank_in, hsync_in, vsync_in;
  logic       ghost_en, palette_sel;
  logic [7:0] r, g, b;
  logic       hblank, vblank, hsync, vsync;

  always #5 clk = ~clk;

  lcd_ghost_blend dut (
    .clk         (clk),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .pixel       (pixel),
    .hblank_in   (hblank_in),
    .vblank_in   (vblank_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .ghost_en    (ghost_en),
    .palette_sel (palette_sel),
    .r           (r),
    .g           (g),
    .b           (b),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  typedef struct {
    int          due;
    logic [27:0] data;
    bit          rst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_count = 0;

  int   model_mem [25600];
  int   model_addr;
  bit   model_first;
  bit   model_prev_vb;
  bit   last_wrote;
  int   last_wr_addr;
  int   last_wr_old;
  int   lvl_tab [4] = '{15, 10, 5, 0};

  // Count ce edges so expectations can be tagged with the edge they are due on.
  always @(posedge clk) if (ce_pix) ce_count <= ce_count + 1;

  function automatic logic [23:0] pal_model(input int i, input bit pal);
    int gg;
    if (pal) begin
      gg = i * 16 + 15;
      if (gg > 255) gg = 255;
      return {8'(i * 8), 8'(gg), 8'(i * 4)};
    end
    return {8'(i * 17), 8'(i * 17), 8'(i * 17)};
  endfunction

  task automatic applyStimulus(input logic [1:0] pix, input bit hb, input bit vb,
                               input bit hs, input bit vs, input bit ghost,
                               input bit pal, input bit rst, input int gap);
    exp_t e;
    int n;
    int iv;
    logic [23:0] rgb;
    repeat (gap) begin
      @(negedge clk);
      ce_pix = 1'b0;
    end
    @(negedge clk);
    pixel = pix; hblank_in = hb; vblank_in = vb; hsync_in = hs; vsync_in = vs;
    ghost_en = ghost; palette_sel = pal; reset = rst; ce_pix = 1'b1;
    e.due = ce_count + 2;
    if (rst) begin
      if (sb.size() > 0 && sb[sb.size()-1].due == ce_count + 1) begin
        sb[sb.size()-1].data = '0;
        sb[sb.size()-1].rst  = 1'b1;
      end
      if (last_wrote) model_mem[last_wr_addr] = last_wr_old;
      last_wrote = 0; model_addr = 0; model_first = 1; model_prev_vb = 0;
      e.data = '0;
      e.rst  = 1'b1;
    end else begin
      rgb = '0;
      last_wrote = 0;
      if (!hb && !vb) begin
        n  = lvl_tab[pix];
        iv = (ghost && !model_first) ? (n + model_mem[model_addr]) / 2 : n;
        last_wrote = 1; last_wr_addr = model_addr; last_wr_old = model_mem[model_addr];
        model_mem[model_addr] = iv;
        rgb = pal_model(iv, pal);
        if (model_addr < 25599) model_addr++;
      end
      if (vb) begin
        model_addr = 0;
        if (!model_prev_vb) model_first = 0;
      end
      model_prev_vb = vb;
      e.data = {rgb, hb, vb, hs, vs};
      e.rst  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [27:0] act;
    act = {r, g, b, hblank, vblank, hsync, vsync};
    checks++;
    if (act !== e.data) begin
      errors++;
      $display("[TB] FAIL %s at ce %0d: got rgb=%0d,%0d,%0d sync=%b, expected rgb=%0d,%0d,%0d sync=%b",
               e.rst ? "reset" : "pixel", e.due, act[27:20], act[19:12], act[11:4], act[3:0],
               e.data[27:20], e.data[19:12], e.data[11:4], e.data[3:0]);
    end
  endtask

  task automatic runFrame(input int lines, input int width, input int split,
                          input logic [1:0] pix_a, input logic [1:0] pix_b,
                          input bit ghost, input bit pal, input int gap, input bit inserts);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < width; x++) begin
        if (inserts && x == 2) applyStimulus(2'd3, 1, 0, 0, 0, 1, pal, 0, gap);
        applyStimulus((y < split) ? pix_a : pix_b, 0, 0, 0, 0, ghost, pal, 0, gap);
      end
      applyStimulus(2'd3, 1, 0, 1, 0, 1, pal, 0, gap);
      applyStimulus(2'd3, 1, 0, 0, 0, 1, pal, 0, gap);
    end
    applyStimulus(2'd3, 1, 1, 0, 0, 1, pal, 0, gap);
    applyStimulus(2'd3, 0, 1, 0, 1, 1, pal, 0, gap);
    applyStimulus(2'd3, 1, 1, 0, 1, 1, pal, 0, gap);
  endtask

  // Monitor: after every ce edge, compare the DUT against the expectation due on that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (ce_pix) begin
        #1;
        while (sb.size() > 0 && sb[0].due < ce_count) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL stale: expectation due at ce %0d not matched by ce %0d", e.due, ce_count);
        end
        if (sb.size() > 0 && sb[0].due == ce_count) begin
          e = sb.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, %0d expectations left", sb.size());
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; ce_pix = 1'b0; pixel = 2'd0;
    hblank_in = 1'b1; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    ghost_en = 1'b0; palette_sel = 1'b0;
    for (int i = 0; i < 25600; i++) model_mem[i] = 0;
    model_addr = 0; model_first = 1; model_prev_vb = 0; last_wrote = 0;
    last_wr_addr = 0; last_wr_old = 0;

    repeat (3) applyStimulus(2'd0, 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) applyStimulus(2'd3, 1, 0, 0, 0, 1, 0, 0, 0);

    $display("[TB] frame 1: pixel=3 first-frame bypass");
    runFrame(2, 4, 2, 2'd3, 2'd3, 1, 0, 0, 0);
    $display("[TB] frames 2-3: pixel=0 grey ghosting");
    runFrame(2, 4, 2, 2'd0, 2'd0, 1, 0, 0, 0);
    runFrame(2, 4, 2, 2'd0, 2'd0, 1, 0, 0, 0);
    $display("[TB] frames 4-5: green palette, ghost off then on");
    runFrame(2, 4, 2, 2'd1, 2'd1, 0, 1, 0, 0);
    runFrame(2, 4, 2, 2'd1, 2'd1, 1, 1, 0, 0);
    $display("[TB] frame 6: 1-in-4 ce duty with mid-line blanking");
    runFrame(2, 4, 2, 2'd2, 2'd2, 1, 0, 3, 1);
    runFrame(2, 4, 2, 2'd0, 2'd0, 1, 0, 0, 0);

    $display("[TB] reset during an active pixel");
    repeat (3) applyStimulus(2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(2'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    repeat (2) applyStimulus(2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(2'd3, 1, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(2'd3, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(2'd3, 0, 1, 0, 1, 1, 0, 0, 0);
    runFrame(1, 4, 1, 2'd0, 2'd0, 1, 0, 0, 0);

    $display("[TB] oversized frame: 200 lines of 160 pixels");
    runFrame(200, 160, 160, 2'd0, 2'd3, 0, 0, 0, 0);
    runFrame(1, 4, 1, 2'd0, 2'd0, 1, 0, 0, 0);

    repeat (3) begin
      @(negedge clk);
      ce_pix = 1'b1;
    end
    @(negedge clk);
    ce_pix = 1'b0;
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_ghost_blend.md
Name: lcd_ghost_blend

Overview:
- Sits directly downstream of the LCD timing/pixel stage; consumes its 2-bit pixel stream plus sync/blank, emits 24-bit RGB to the video output path.
- Emulates Supervision LCD persistence (ghosting) by averaging each pixel with its value from the previous frame, held in an internal 160x160 frame store.
- Maps the blended intensity through a selectable palette (grey or green LCD tint).

Parameters:
- MAX_W, 160, active pixels per line held in the frame store
- MAX_H, 160, active lines held in the frame store
- I_W, 4, intensity width in bits, per stored pixel

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel clock enable from the LCD stage
- pixel  in  2  LCD level: 0 = blank/lightest, 3 = darkest
- hblank_in  in  1  LCD hblank
- vblank_in  in  1  LCD vblank
- hsync_in  in  1  LCD hsync
- vsync_in  in  1  LCD vsync
- ghost_en  in  1  1 = blend with previous frame; 0 = pass-through
- palette_sel  in  1  0 = grey, 1 = green tint
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- hblank  out  1  hblank delayed to match RGB
- vblank  out  1  vblank delayed to match RGB
- hsync  out  1  hsync delayed to match RGB
- vsync  out  1  vsync delayed to match RGB

Behaviour:
- Everything advances only on cycles with ce_pix=1. The reset branch is evaluated after the ce branch and takes priority.
- Reset values:
  - r, g, b, hblank, vblank, hsync, vsync, write address and read address all = 0.
  - first_frame = 1.
  - Frame store contents are not cleared.
- Active pixel: hblank_in=0 and vblank_in=0.
- Address counter (15 bits):
  - Cleared to 0 on any ce cycle with vblank_in=1.
  - Increments by 1 after each active pixel.
  - Saturates at MAX_W*MAX_H-1 (25599); never wraps.
- Pipeline: 2 ce cycles of latency; RGB and all four sync/blank outputs are delayed identically.
  - Stage 0: compute new intensity N = 15 - 5*pixel, giving 15/10/5/0. Present the counter address to the store read port. Register N, the address, an active flag and the sync/blank signals.
  - Stage 1: store data O is valid.
    - Blended value B = (N + O) >> 1 (5-bit sum, truncate).
    - Use B when ghost_en=1 and first_frame=0; otherwise use N.
    - Write the selected intensity to the store at the stage-0 address, only if the stage-1 active flag is set.
    - Drive palette outputs and the delayed sync/blank signals.
  - Read and write to the same address never collide within a frame: the write lags the read by 1 ce, and the address is monotonic.
- first_frame clears on the first ce cycle where vblank_in rises (0 to 1) after reset. This bypasses blending against undefined store contents for the first frame.
- Palette, with I = the selected 4-bit intensity:
  - Grey (palette_sel=0): r = g = b = I*17, so 0..255.
  - Green (palette_sel=1): r = I*8, g = min(I*16+15, 255), b = I*4.
- Inactive pixels (blanking) output r = g = b = 0 and perform no store write.
- ghost_en and palette_sel are sampled every ce cycle; a mid-frame change takes effect on the next pixel. The store keeps being updated in both ghost modes.
- Reset mid-frame:
  - Pipeline, counter and outputs return to reset values on the next clk.
  - An in-flight stage-1 write in that cycle is suppressed.

Decomposition:
- Package lcd_video_pkg:
  - MAX_W, MAX_H and the frame-store depth (25600).
  - An intensity typedef (logic [3:0]).
  - A pal_sel_e enum (GREY, GREEN).
  - The level-to-intensity function.
  - The palette function.
- Sub-module lcd_ghost_ram: simple dual-port RAM, 25600 x 4 bits, with one registered read port and one write port on clk. Read latency is 1 cycle and read-during-write is don't-care. It is infer-friendly so it maps to M10K.

Test Plan:
- Reset, then a first frame of all pixel=3 with ghost_en=1 -> first_frame bypass; RGB = 0,0,0 on every active pixel, 2 ce after input.
- Second frame all pixel=0 with ghost_en=1, grey -> I = (15+0)>>1 = 7, RGB = 119,119,119. Third frame all pixel=0 -> I = (15+7)>>1 = 11, RGB = 187,187,187.
- ghost_en=0, palette_sel=1, pixel=1 -> I = 10, RGB = 80,175,40. The stored value is also 10; the next frame with ghost_en=1 and pixel=1 gives I = 10.
- Blanking check: hblank_in/vblank_in toggled -> outputs are the same waveforms delayed by exactly 2 ce_pix pulses; RGB = 0 and no RAM write during blanking. Verify with ce_pix at a 1-in-4 duty.
- Oversized active region (200 active lines) -> address sticks at 25599 and does not wrap; the counter is 0 again on the first active pixel after vblank.
- Reset asserted mid-line during an active pixel -> next clk: all outputs 0, counter 0, no RAM write that cycle, first_frame=1.
